// File: rtl/up_axi_pkg.sv
// Shared types and constants for the AXI4-Lite to up-bus bridge.
package up_axi_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_WAIT,
        S_WR_RESP,
        S_RD_REQ,
        S_RD_WAIT,
        S_RD_RESP
    } state_t;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [31:0] RD_ERR_DATA = 32'hDEAD_DEAD;
    localparam logic [3:0]  STRB_FULL   = 4'hF;

    function automatic logic is_full_strobe(input logic [3:0] strb);
        return strb == STRB_FULL;
    endfunction

endpackage

// File: rtl/up_axi_tmo.sv
// Up-bus ack watchdog: loadable down-counter with an expiry flag.
// Built only when UP_AXI_TIMEOUT_EN is defined.
module up_axi_tmo #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expired
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT - 2);

    logic [CW-1:0] cnt;

    // Loaded on the strobe cycle so that it reaches zero on the last
    // cycle in which an ack is still honoured.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/up_axi_slave.sv
// AXI4-Lite slave bridging single-word accesses onto the up-bus.
// Optional ack watchdog enabled by defining UP_AXI_TIMEOUT_EN.
module up_axi_slave
    import up_axi_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 12,
    parameter int TIMEOUT       = 256
) (
    input  logic                     up_clk,
    input  logic                     up_rst,
    input  logic                     s_axi_awvalid,
    output logic                     s_axi_awready,
    input  logic [ADDRESS_WIDTH+1:0] s_axi_awaddr,
    input  logic                     s_axi_wvalid,
    output logic                     s_axi_wready,
    input  logic [31:0]              s_axi_wdata,
    input  logic [3:0]               s_axi_wstrb,
    output logic                     s_axi_bvalid,
    input  logic                     s_axi_bready,
    output logic [1:0]               s_axi_bresp,
    input  logic                     s_axi_arvalid,
    output logic                     s_axi_arready,
    input  logic [ADDRESS_WIDTH+1:0] s_axi_araddr,
    output logic                     s_axi_rvalid,
    input  logic                     s_axi_rready,
    output logic [31:0]              s_axi_rdata,
    output logic [1:0]               s_axi_rresp,
    output logic                     up_wreq,
    output logic [ADDRESS_WIDTH-1:0] up_waddr,
    output logic [31:0]              up_wdata,
    input  logic                     up_wack,
    output logic                     up_rreq,
    output logic [ADDRESS_WIDTH-1:0] up_raddr,
    input  logic [31:0]              up_rdata,
    input  logic                     up_rack
);

    state_t state;
    logic   wr_prio;
    logic   wr_elig;
    logic   rd_elig;
    logic   idle_free;
    logic   wr_grant;
    logic   rd_grant;
    logic   tmo_exp;
    logic   addr_lsb_unused;

    assign addr_lsb_unused = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    assign wr_elig   = s_axi_awvalid && s_axi_wvalid;
    assign rd_elig   = s_axi_arvalid;
    assign idle_free = (state == S_IDLE) && !s_axi_bvalid
                       && !s_axi_rvalid && !up_rst;

    // Round-robin between the channels only when both are presented.
    assign wr_grant = idle_free && wr_elig
                      && (wr_prio || !rd_elig);
    assign rd_grant = idle_free && rd_elig
                      && (!wr_elig || !wr_prio);

    assign s_axi_awready = wr_grant;
    assign s_axi_wready  = wr_grant;
    assign s_axi_arready = rd_grant;

`ifdef UP_AXI_TIMEOUT_EN
    logic tmo_load;

    assign tmo_load = (state == S_WR_REQ) || (state == S_RD_REQ);

    up_axi_tmo #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk     (up_clk),
        .rst     (up_rst),
        .load    (tmo_load),
        .expired (tmo_exp)
    );
`else
    localparam int timeout_unused = TIMEOUT;

    assign tmo_exp = 1'b0;
`endif

    always_ff @(posedge up_clk) begin
        if (up_rst) begin
            state        <= S_IDLE;
            wr_prio      <= 1'b1;
            up_wreq      <= 1'b0;
            up_waddr     <= '0;
            up_wdata     <= '0;
            up_rreq      <= 1'b0;
            up_raddr     <= '0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= RESP_OKAY;
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
            s_axi_rresp  <= RESP_OKAY;
        end else begin
            up_wreq <= 1'b0;
            up_rreq <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (wr_grant) begin
                        wr_prio  <= 1'b0;
                        up_waddr <= s_axi_awaddr[ADDRESS_WIDTH+1:2];
                        up_wdata <= s_axi_wdata;
                        if (is_full_strobe(s_axi_wstrb)) begin
                            up_wreq <= 1'b1;
                            state   <= S_WR_REQ;
                        end else begin
                            s_axi_bvalid <= 1'b1;
                            s_axi_bresp  <= RESP_SLVERR;
                            state        <= S_WR_RESP;
                        end
                    end else if (rd_grant) begin
                        wr_prio  <= 1'b1;
                        up_raddr <= s_axi_araddr[ADDRESS_WIDTH+1:2];
                        up_rreq  <= 1'b1;
                        state    <= S_RD_REQ;
                    end
                end
                S_WR_REQ: begin
                    if (up_wack) begin
                        s_axi_bvalid <= 1'b1;
                        s_axi_bresp  <= RESP_OKAY;
                        state        <= S_WR_RESP;
                    end else begin
                        state <= S_WR_WAIT;
                    end
                end
                S_WR_WAIT: begin
                    if (up_wack) begin
                        s_axi_bvalid <= 1'b1;
                        s_axi_bresp  <= RESP_OKAY;
                        state        <= S_WR_RESP;
                    end else if (tmo_exp) begin
                        s_axi_bvalid <= 1'b1;
                        s_axi_bresp  <= RESP_SLVERR;
                        state        <= S_WR_RESP;
                    end
                end
                S_WR_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                S_RD_REQ: begin
                    if (up_rack) begin
                        s_axi_rvalid <= 1'b1;
                        s_axi_rdata  <= up_rdata;
                        s_axi_rresp  <= RESP_OKAY;
                        state        <= S_RD_RESP;
                    end else begin
                        state <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (up_rack) begin
                        s_axi_rvalid <= 1'b1;
                        s_axi_rdata  <= up_rdata;
                        s_axi_rresp  <= RESP_OKAY;
                        state        <= S_RD_RESP;
                    end else if (tmo_exp) begin
                        s_axi_rvalid <= 1'b1;
                        s_axi_rdata  <= RD_ERR_DATA;
                        s_axi_rresp  <= RESP_SLVERR;
                        state        <= S_RD_RESP;
                    end
                end
                S_RD_RESP: begin
                    if (s_axi_rready) begin
                        s_axi_rvalid <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_up_axi_slave.sv
// Randomized scoreboard bench for up_axi_slave with an up-bus
// slave model and a transaction-level reference model.
module tb_up_axi_slave;

    localparam int AW  = 12;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          up_rst;
    logic          awvalid, awready, wvalid, wready;
    logic [AW+1:0] awaddr, araddr;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          bvalid, bready, arvalid, arready;
    logic          rvalid, rready;
    logic [1:0]    bresp, rresp;
    logic [31:0]   rdata;
    logic          up_wreq, up_rreq, up_wack, up_rack;
    logic [AW-1:0] up_waddr, up_raddr;
    logic [31:0]   up_wdata, up_rdata;

    always #5 clk = ~clk;

    up_axi_slave #(
        .ADDRESS_WIDTH (AW),
        .TIMEOUT       (TMO)
    ) dut (
        .up_clk        (clk),
        .up_rst        (up_rst),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_awaddr  (awaddr),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_bresp   (bresp),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_araddr  (araddr),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .up_wreq       (up_wreq),
        .up_waddr      (up_waddr),
        .up_wdata      (up_wdata),
        .up_wack       (up_wack),
        .up_rreq       (up_rreq),
        .up_raddr      (up_raddr),
        .up_rdata      (up_rdata),
        .up_rack       (up_rack)
    );

    typedef struct {
        bit          wr;
        logic [AW-1:0] addr;
        logic [31:0] data;
    } strb_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    strb_t       sq[$];
    logic [1:0]  bq[$];
    rexp_t       rq[$];
    logic [31:0] ref_mem[4096];
    logic [31:0] slv_mem[4096];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int ack_delay = -1;
    bit prio_w = 1'b1;
    bit noack = 1'b0;
    bit hold_b = 1'b0;
    bit hold_r = 1'b0;
    bit spur_en = 1'b0;
    bit force_rack = 1'b0;
    logic [31:0] force_data = 32'h0;
    int rreq_cyc = 0;
    int rrise_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout/unexpected expected event", name);
    endtask

    function automatic logic [127:0] all_outs();
        return {awready, wready, bvalid, bresp, arready, rvalid,
                rdata, rresp, up_wreq, up_waddr, up_wdata,
                up_rreq, up_raddr};
    endfunction

    task automatic model_write(logic [AW-1:0] a, logic [31:0] d,
                               logic [3:0] s);
        strb_t e;
        if (s == 4'hF) begin
            e.wr = 1'b1; e.addr = a; e.data = d;
            sq.push_back(e);
            ref_mem[a] = d;
            bq.push_back(2'b00);
        end else begin
            bq.push_back(2'b10);
        end
        prio_w = 1'b0;
    endtask

    task automatic model_read(logic [AW-1:0] a);
        strb_t e;
        rexp_t r;
        e.wr = 1'b0; e.addr = a; e.data = '0;
        sq.push_back(e);
        r.data = ref_mem[a]; r.resp = 2'b00;
        rq.push_back(r);
        prio_w = 1'b1;
    endtask

    task automatic axi_issue(bit do_w, bit do_r, logic [AW+1:0] wa,
                             logic [31:0] wd, logic [3:0] ws,
                             logic [AW+1:0] ra, bit model);
        bit w_first;
        bit w_pend;
        bit r_pend;
        bit w_acc;
        bit r_acc;
        int t;
        if (model) begin
            w_first = (do_w && do_r) ? prio_w : do_w;
            if (w_first) begin
                model_write(wa[AW+1:2], wd, ws);
                if (do_r) model_read(ra[AW+1:2]);
            end else begin
                if (do_r) model_read(ra[AW+1:2]);
                if (do_w) model_write(wa[AW+1:2], wd, ws);
            end
        end
        @(negedge clk);
        awvalid = do_w; wvalid = do_w;
        awaddr = wa; wdata = wd; wstrb = ws;
        arvalid = do_r; araddr = ra;
        w_pend = do_w; r_pend = do_r;
        t = 0;
        while ((w_pend || r_pend) && t < 300) begin
            #1;
            w_acc = w_pend && awready;
            r_acc = r_pend && arready;
            if (w_pend) chk("aw_w_together", awready, wready);
            if (w_acc || r_acc) chk("single_grant", w_acc && r_acc, 1'b0);
            @(negedge clk);
            t++;
            if (w_acc) begin
                awvalid = 1'b0; wvalid = 1'b0;
                wdata = $urandom; w_pend = 1'b0;
            end
            if (r_acc) begin
                arvalid = 1'b0; r_pend = 1'b0;
            end
        end
        if (w_pend || r_pend) begin
            awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
            fail("accept_timeout");
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((sq.size() != 0 || bq.size() != 0 || rq.size() != 0)
               && t < 600) begin
            @(negedge clk);
            t++;
        end
        if (t >= 600) fail("drain_timeout");
        repeat (2) @(negedge clk);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            bready = !hold_b && ($urandom_range(3) != 0);
            rready = !hold_r && ($urandom_range(3) != 0);
        end
    end

    initial begin
        int w_dly = -1;
        int r_dly = -1;
        bit acked;
        up_wack = 1'b0; up_rack = 1'b0; up_rdata = '0;
        forever begin
            @(negedge clk);
            up_wack = 1'b0; up_rack = 1'b0; up_rdata = $urandom;
            acked = 1'b0;
            if (up_rst) begin
                w_dly = -1; r_dly = -1;
            end
            if (up_wreq && !noack)
                w_dly = (ack_delay < 0) ? $urandom_range(1) : ack_delay;
            if (up_rreq && !noack)
                r_dly = (ack_delay < 0) ? $urandom_range(1) : ack_delay;
            if (w_dly == 0) begin
                up_wack = 1'b1; acked = 1'b1;
                slv_mem[up_waddr] = up_wdata;
            end
            if (r_dly == 0) begin
                up_rack = 1'b1; acked = 1'b1;
                up_rdata = slv_mem[up_raddr];
            end
            if (w_dly >= 0) w_dly--;
            if (r_dly >= 0) r_dly--;
            if (force_rack) begin
                up_rack = 1'b1; up_rdata = force_data;
                force_rack = 1'b0;
            end else if (spur_en && !acked && w_dly < 0 && r_dly < 0
                         && !up_wreq && !up_rreq
                         && $urandom_range(7) == 0) begin
                if ($urandom_range(1) == 0) up_wack = 1'b1;
                else up_rack = 1'b1;
            end
        end
    end

    initial begin
        bit p_wreq = 1'b0;
        bit p_rvalid = 1'b0;
        bit p_bhold = 1'b0;
        logic [1:0] p_bresp = '0;
        strb_t e;
        rexp_t r;
        forever begin
            @(negedge clk);
            #2;
            if (!up_rst) begin
                if (up_wreq || up_rreq) begin
                    chk("strobe_excl", up_wreq && up_rreq, 1'b0);
                    if (up_rreq) rreq_cyc = cyc;
                    if (sq.size() == 0) begin
                        fail("strobe_unexpected");
                    end else begin
                        e = sq.pop_front();
                        chk("strobe_kind", up_wreq, e.wr);
                        if (e.wr) begin
                            chk("up_waddr", up_waddr, e.addr);
                            chk("up_wdata", up_wdata, e.data);
                        end else begin
                            chk("up_raddr", up_raddr, e.addr);
                        end
                    end
                end
                if (up_wreq) chk("wreq_pulse", p_wreq, 1'b0);
                if (p_bhold) begin
                    chk("bvalid_held", bvalid, 1'b1);
                    chk("bresp_stable", bresp, p_bresp);
                end
                if (bvalid && bready) begin
                    if (bq.size() == 0) fail("b_unexpected");
                    else chk("bresp", bresp, bq.pop_front());
                end
                if (rvalid && !p_rvalid) rrise_cyc = cyc;
                if (rvalid && rready) begin
                    if (rq.size() == 0) begin
                        fail("r_unexpected");
                    end else begin
                        r = rq.pop_front();
                        chk("rdata", rdata, r.data);
                        chk("rresp", rresp, r.resp);
                    end
                end
            end
            p_wreq = up_wreq;
            p_rvalid = rvalid;
            p_bhold = bvalid && !bready && !up_rst;
            p_bresp = bresp;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW+1:0] a0;
        logic [AW+1:0] a1;
        logic [3:0]    s;
        int            k;
        int            t;
        bit            seen;
        rexp_t         r;
        strb_t         e;
        for (int i = 0; i < 4096; i++) begin
            ref_mem[i] = i * 32'h9E37_79B1;
            slv_mem[i] = i * 32'h9E37_79B1;
        end
        ref_mem[2] = 32'h34;
        slv_mem[2] = 32'h34;
        up_rst = 1'b1;
        awvalid = 0; wvalid = 0; arvalid = 0;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        repeat (3) @(negedge clk);
        up_rst = 1'b0;
        #2;
        chk("reset_outputs", all_outs(), '0);

        ack_delay = 1;
        axi_issue(1, 0, 14'h000, 32'h0001_0800, 4'hF, '0, 1);
        drain();

        ack_delay = 0;
        axi_issue(1, 0, 14'h00C, 32'h4, 4'hF, '0, 1);
        axi_issue(0, 1, '0, '0, 4'h0, 14'h008, 1);
        drain();

        ack_delay = -1;
        axi_issue(1, 1, 14'h014, 32'h5555_0005, 4'hF, 14'h01C, 1);
        axi_issue(1, 1, 14'h018, 32'h6666_0006, 4'hF, 14'h014, 1);
        drain();

        axi_issue(1, 0, 14'h024, 32'hBAD0_0009, 4'h3, '0, 1);
        axi_issue(1, 0, 14'h024, 32'h600D_0009, 4'hF, '0, 1);
        axi_issue(0, 1, '0, '0, 4'h0, 14'h024, 1);
        drain();

        spur_en = 1'b1;
        for (int i = 0; i < 150; i++) begin
            k  = $urandom_range(2);
            a0 = {($urandom_range(9) == 0) ? 12'hFFF : 12'($urandom_range(15)),
                  2'($urandom_range(3))};
            a1 = {($urandom_range(9) == 0) ? 12'hFFF : 12'($urandom_range(15)),
                  2'($urandom_range(3))};
            s  = ($urandom_range(3) == 0) ? 4'($urandom) : 4'hF;
            axi_issue(k != 1, k != 0, a0, $urandom, s, a1, 1);
        end
        drain();
        spur_en = 1'b0;

        hold_b = 1'b1;
        axi_issue(1, 0, 14'h028, 32'hA5A5_000A, 4'hF, '0, 1);
        t = 0;
        while (!bvalid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bvalid) fail("bvalid_wait");
        model_read(12'd11);
        arvalid = 1'b1;
        araddr = 14'h02C;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("arready_blocked", arready, 1'b0);
            @(negedge clk);
        end
        noack = 1'b1;
        hold_b = 1'b0;
        t = 0;
        #1;
        while (!arready && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!arready) fail("ar_accept_wait");
        @(negedge clk);
        arvalid = 1'b0;
        t = 0;
        while (sq.size() != 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (sq.size() != 0) fail("rreq_wait");
        repeat (2) @(negedge clk);
        up_rst = 1'b1;
        sq.delete(); bq.delete(); rq.delete();
        prio_w = 1'b1;
        repeat (2) @(negedge clk);
        up_rst = 1'b0;
        #2;
        chk("post_reset_outputs", all_outs(), '0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #2;
            if (rvalid) seen = 1'b1;
        end
        chk("no_rvalid_after_reset", seen, 1'b0);

`ifdef UP_AXI_TIMEOUT_EN
        hold_r = 1'b1;
        e.wr = 1'b0; e.addr = 12'd12; e.data = '0;
        sq.push_back(e);
        r.data = 32'hDEAD_DEAD; r.resp = 2'b10;
        rq.push_back(r);
        prio_w = 1'b1;
        axi_issue(0, 1, '0, '0, 4'h0, 14'h030, 0);
        t = 0;
        while (!rvalid && t < 100) begin
            @(negedge clk);
            #3;
            t++;
        end
        if (!rvalid) fail("tmo_rvalid_wait");
        chk("tmo_latency", rrise_cyc - rreq_cyc, TMO);
        force_data = 32'h1234_5678;
        force_rack = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk("late_rack_rdata", rdata, 32'hDEAD_DEAD);
        chk("late_rack_rresp", rresp, 2'b10);
        hold_r = 1'b0;
        drain();
        e.wr = 1'b1; e.addr = 12'd13; e.data = 32'h7777_000D;
        sq.push_back(e);
        bq.push_back(2'b10);
        prio_w = 1'b0;
        axi_issue(1, 0, 14'h034, 32'h7777_000D, 4'hF, '0, 0);
        drain();
        noack = 1'b0;
        axi_issue(0, 1, '0, '0, 4'h0, 14'h034, 1);
        drain();
`else
        e.wr = 1'b0; e.addr = 12'd12; e.data = '0;
        sq.push_back(e);
        force_data = 32'hC0DE_0012;
        r.data = force_data; r.resp = 2'b00;
        rq.push_back(r);
        prio_w = 1'b1;
        axi_issue(0, 1, '0, '0, 4'h0, 14'h030, 0);
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #2;
            if (rvalid) seen = 1'b1;
        end
        chk("no_timeout_wait", seen, 1'b0);
        force_rack = 1'b1;
        drain();
        noack = 1'b0;
`endif

        ack_delay = -1;
        axi_issue(1, 0, 14'h3FFC, 32'hFEED_0FFF, 4'hF, '0, 1);
        axi_issue(0, 1, '0, '0, 4'h0, 14'h3FFD, 1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/up_axi_slave.md
Name: up_axi_slave

Overview:
AXI4-Lite slave that converts host register accesses into single-word up-bus transactions for up_spi_ctl and its sibling peripherals. It sits directly upstream of up_spi_ctl and drives its up_wreq/up_waddr/up_wdata and up_rreq/up_raddr ports. It owns read/write arbitration, the byte-to-word address conversion and AXI response generation. Only one transaction is outstanding at a time.

Parameters:
ADDRESS_WIDTH, 12, up-bus word-address width; AXI byte address is ADDRESS_WIDTH+2 bits.
TIMEOUT, 256, up-bus ack timeout in cycles; used only with UP_AXI_TIMEOUT_EN; must be ≥2.

Ports:
up_clk  in  1  single clock for AXI and up-bus sides
up_rst  in  1  synchronous, active-high reset
s_axi_awvalid/s_axi_awready  in/out  1  write address handshake
s_axi_awaddr  in  ADDRESS_WIDTH+2  byte address
s_axi_wvalid/s_axi_wready  in/out  1  write data handshake
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte strobes
s_axi_bvalid/s_axi_bready  out/in  1  write response handshake
s_axi_bresp  out  2  write response
s_axi_arvalid/s_axi_arready  in/out  1  read address handshake
s_axi_araddr  in  ADDRESS_WIDTH+2  byte address
s_axi_rvalid/s_axi_rready  out/in  1  read data handshake
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  read response
up_wreq  out  1  one-cycle write strobe
up_waddr  out  ADDRESS_WIDTH  word address
up_wdata  out  32  write data
up_wack  in  1  write acknowledge pulse
up_rreq  out  1  one-cycle read strobe
up_raddr  out  ADDRESS_WIDTH  word address
up_rdata  in  32  read data, valid when up_rack=1
up_rack  in  1  read acknowledge pulse

Behaviour:
- Clock up_clk; reset synchronous, active-high (up_rst). Reset drives all outputs to 0, state to IDLE and wr_prio to 1. Reset mid-transaction aborts it; no response is issued.
- States: IDLE, WR_REQ, WR_WAIT, WR_RESP, RD_REQ, RD_WAIT, RD_RESP.
- IDLE: write is eligible when awvalid&&wvalid; read is eligible when arvalid. AW and W are accepted only together.
- Arbitration: if only one side is eligible, serve it. If both are eligible, serve write when wr_prio=1, else read. After each grant, wr_prio toggles to favour the other side.
- Accept write: awready=wready=1 for one cycle (combinational in IDLE on the grant). Latch awaddr[ADDRESS_WIDTH+1:2] and wdata. Ignore awaddr[1:0].
  - wstrb==4'hF → WR_REQ.
  - Otherwise → WR_RESP with bresp=2'b10 (SLVERR); no up_wreq is issued.
- WR_REQ: up_wreq=1 for exactly one cycle, with up_waddr/up_wdata valid. Next state is WR_WAIT; if up_wack=1 in the same cycle, go straight to WR_RESP with OKAY.
- WR_WAIT: hold until up_wack=1, then WR_RESP with bresp=2'b00. up_waddr/up_wdata stay stable until the ack.
- WR_RESP: bvalid=1 until bready; then IDLE. bresp is stable while bvalid=1.
- Read path mirrors the write path: arready pulse, RD_REQ issues a one-cycle up_rreq, RD_WAIT captures up_rdata on up_rack, RD_RESP holds rvalid/rdata/rresp until rready.
- Latency, zero-wait up-bus slave: accept at cycle N, strobe at N+1, ack at N+1 or N+2, bvalid/rvalid at N+2 or N+3.
- up_wack/up_rack received in any state other than the matching WAIT/REQ state are ignored, including late acks after a timeout.
- No new AXI accept occurs while a response is pending (bvalid or rvalid high).

Optional Feature:
UP_AXI_TIMEOUT_EN.
- Defined: a counter starts at the strobe cycle. If no ack arrives within TIMEOUT cycles after the strobe, the state moves to the RESP state with resp=2'b10. For reads, rdata=32'hDEAD_DEAD.
- Undefined: the WAIT states have no limit; no counter logic is synthesized.

Decomposition:
- Package up_axi_pkg: state enum; RESP_OKAY=2'b00 and RESP_SLVERR=2'b10; RD_ERR_DATA=32'hDEAD_DEAD; full-strobe constant 4'hF.
- One sub-module, up_axi_tmo: loadable down-counter with an expiry flag, instantiated only under UP_AXI_TIMEOUT_EN.
- Everything else is a single FSM in up_axi_slave.

Test Plan:
- Write awaddr=0x000, wdata=0x10800, wstrb=F; slave acks 1 cycle after strobe → one-cycle up_wreq with up_waddr=0 and up_wdata=0x10800; bresp=OKAY after the ack.
- Write awaddr=0x00C (word 3), wdata=4, then read araddr=0x008 with the slave returning 0x34 → up_waddr=3; up_raddr=2; rdata=0x34, rresp=OKAY.
- AW+W and AR valid in the same IDLE cycle, issued twice back-to-back → first pair: write served first, then read; second pair: read served first. Never two strobes in one cycle.
- wstrb=4'h3 → no up_wreq; bresp=SLVERR; next full-strobe write proceeds normally.
- With UP_AXI_TIMEOUT_EN and TIMEOUT=16, slave never acks a read → rvalid with rresp=SLVERR and rdata=0xDEADDEAD 16 cycles after up_rreq; a late up_rack is ignored.
- Hold bready low 5 cycles while AR is pending; assert up_rst during RD_WAIT → bvalid held and arready stays 0 until the B handshake; after reset all outputs are 0 and no rvalid appears.
